// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the parametrised UART blocks.
//   tx_state_e          transmitter FSM state encoding
//   PAR_EVEN / PAR_ODD  parity-type selector values
//   DEF_DATA_WIDTH      default data bits per frame
//   DEF_PRESC_W         default width of the prescale input
package uart_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_PRESC_W    = 6;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_STOP2
  } tx_state_e;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// uart_tx_bit_timer: per-bit prescale down-counter.
//   clk, rst_n   clock, asynchronous active-low reset
//   load         restart the count for a new bit
//   prescale     clocks per bit (0 is treated as 1), sampled on load
//   bit_done_c   high in the last cycle of the current bit (counter at 0)
module uart_tx_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned PRESC_W = DEF_PRESC_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [PRESC_W-1:0] prescale,
  output logic               bit_done_c
);

  logic [PRESC_W-1:0] cnt;

  // Reload with max(prescale,1)-1, then count down and park at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= (prescale == '0) ? '0 : prescale - PRESC_W'(1);
    end else if (cnt != '0) begin
      cnt <= cnt - PRESC_W'(1);
    end
  end

  assign bit_done_c = (cnt == '0);

endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter.
// Frame: start(0), DATA_WIDTH data bits LSB first, optional parity, 1 or 2
// stop bits; each bit lasts max(PRESCALE,1) clocks. Frame configuration is
// captured with the word at acceptance.
// Build option: define UART_TX_HOLD_EN for a one-word holding register that
// allows gap-free back-to-back frames.
//   CLK, RST        clock, asynchronous active-low reset
//   P_DATA          word to send
//   DATA_VALID      P_DATA valid
//   DATA_READY      word can be accepted this cycle
//   PAR_EN/PAR_TYP  parity enable / type (0 even, 1 odd)
//   STOP2           two stop bits
//   PRESCALE        clocks per bit
//   TX_OUT          serial line, idle high
//   Busy            frame in progress
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned PRESC_W    = DEF_PRESC_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  output logic                  DATA_READY,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic [PRESC_W-1:0]    PRESCALE,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  tx_state_e state, next_state;

  logic [DATA_WIDTH-1:0] cfg_data;
  logic                  cfg_par_en;
  logic                  cfg_par_typ;
  logic                  cfg_stop2;
  logic [PRESC_W-1:0]    cfg_presc;
  logic [IDX_W-1:0]      bit_idx;

  logic                  bit_done_c;
  logic                  accept_c;
  logic                  start_c;
  logic                  frame_end_c;
  logic                  load_c;
  logic                  ready_c;
  logic                  tx_c;
  logic                  busy_c;
  logic [PRESC_W-1:0]    timer_presc_c;

  // Configuration for the frame about to start (from hold or from inputs).
  logic [DATA_WIDTH-1:0] nxt_data_c;
  logic                  nxt_par_en_c;
  logic                  nxt_par_typ_c;
  logic                  nxt_stop2_c;
  logic [PRESC_W-1:0]    nxt_presc_c;
  logic                  hold_full;

  assign accept_c    = DATA_VALID && DATA_READY;
  assign frame_end_c = bit_done_c &&
                       (((state == ST_STOP) && !cfg_stop2) || (state == ST_STOP2));
  assign start_c     = ((state == ST_IDLE) && (accept_c || hold_full)) ||
                       (frame_end_c && hold_full);
  assign load_c      = start_c || ((state != ST_IDLE) && bit_done_c);
  assign timer_presc_c = start_c ? nxt_presc_c : cfg_presc;

`ifdef UART_TX_HOLD_EN
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  hold_par_en;
  logic                  hold_par_typ;
  logic                  hold_stop2;
  logic [PRESC_W-1:0]    hold_presc;
  logic                  hold_wr_c;
  logic                  hold_rd_c;

  // Words accepted while a frame is running park here; a full hold always
  // supplies the next frame, and DATA_READY is held low while it is full.
  assign hold_wr_c = accept_c && (state != ST_IDLE);
  assign hold_rd_c = start_c && hold_full;
  assign ready_c   = !((hold_full && !hold_rd_c) || hold_wr_c);

  assign nxt_data_c    = hold_full ? hold_data    : P_DATA;
  assign nxt_par_en_c  = hold_full ? hold_par_en  : PAR_EN;
  assign nxt_par_typ_c = hold_full ? hold_par_typ : PAR_TYP;
  assign nxt_stop2_c   = hold_full ? hold_stop2   : STOP2;
  assign nxt_presc_c   = hold_full ? hold_presc   : PRESCALE;

  // Holding register: data plus its latched frame configuration.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hold_full    <= 1'b0;
      hold_data    <= '0;
      hold_par_en  <= 1'b0;
      hold_par_typ <= 1'b0;
      hold_stop2   <= 1'b0;
      hold_presc   <= '0;
    end else if (hold_wr_c) begin
      hold_full    <= 1'b1;
      hold_data    <= P_DATA;
      hold_par_en  <= PAR_EN;
      hold_par_typ <= PAR_TYP;
      hold_stop2   <= STOP2;
      hold_presc   <= PRESCALE;
    end else if (hold_rd_c) begin
      hold_full    <= 1'b0;
    end
  end
`else
  assign hold_full     = 1'b0;
  assign ready_c       = (next_state == ST_IDLE);
  assign nxt_data_c    = P_DATA;
  assign nxt_par_en_c  = PAR_EN;
  assign nxt_par_typ_c = PAR_TYP;
  assign nxt_stop2_c   = STOP2;
  assign nxt_presc_c   = PRESCALE;
`endif

  uart_tx_bit_timer #(
    .PRESC_W (PRESC_W)
  ) u_timer (
    .clk        (CLK),
    .rst_n      (RST),
    .load       (load_c),
    .prescale   (timer_presc_c),
    .bit_done_c (bit_done_c)
  );

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (start_c) next_state = ST_START;
      ST_START:  if (bit_done_c) next_state = ST_DATA;
      ST_DATA:   if (bit_done_c && (bit_idx == LAST_IDX))
                   next_state = cfg_par_en ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_done_c) next_state = ST_STOP;
      ST_STOP:   if (bit_done_c) begin
                   if (cfg_stop2)    next_state = ST_STOP2;
                   else if (start_c) next_state = ST_START;
                   else              next_state = ST_IDLE;
                 end
      ST_STOP2:  if (bit_done_c) next_state = start_c ? ST_START : ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Output decode; the values are registered one cycle later.
  always_comb begin
    tx_c   = 1'b1;
    busy_c = (state != ST_IDLE);
    case (state)
      ST_START:  tx_c = 1'b0;
      ST_DATA:   tx_c = cfg_data[bit_idx];
      ST_PARITY: begin
        case (cfg_par_typ)
          PAR_EVEN: tx_c = ^cfg_data;
          PAR_ODD:  tx_c = ~^cfg_data;
          default:  tx_c = 1'b1;
        endcase
      end
      default:   tx_c = 1'b1;
    endcase
  end

  // Frame configuration, bit index and registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cfg_data    <= '0;
      cfg_par_en  <= 1'b0;
      cfg_par_typ <= 1'b0;
      cfg_stop2   <= 1'b0;
      cfg_presc   <= '0;
      bit_idx     <= '0;
      TX_OUT      <= 1'b1;
      Busy        <= 1'b0;
      DATA_READY  <= 1'b1;
    end else begin
      if (start_c) begin
        cfg_data    <= nxt_data_c;
        cfg_par_en  <= nxt_par_en_c;
        cfg_par_typ <= nxt_par_typ_c;
        cfg_stop2   <= nxt_stop2_c;
        cfg_presc   <= nxt_presc_c;
      end
      if (start_c) begin
        bit_idx <= '0;
      end else if ((state == ST_DATA) && bit_done_c) begin
        bit_idx <= (bit_idx == LAST_IDX) ? '0 : bit_idx + IDX_W'(1);
      end
      TX_OUT     <= tx_c;
      Busy       <= busy_c;
      DATA_READY <= ready_c;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: self-checking bench for uart_tx_param.
// Table of hand-derived frames, randomized frames against a bit-list model,
// plus back-to-back, reset-abort and 7-bit-instance sequences.
// Expectations follow UART_TX_HOLD_EN when it is defined for the build.
module tb_uart_tx_param;
  import uart_pkg::*;

`ifdef UART_TX_HOLD_EN
  localparam logic HOLD = 1'b1;
`else
  localparam logic HOLD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] p_data;
  logic       data_valid, data_ready, par_en, par_typ, stop2, tx_out, busy;
  logic [5:0] prescale;

  logic [6:0] d7;
  logic       v7, r7, tx7, busy7;

  int vectors = 0;
  int miscompares = 0;

  logic [127:0] cap;

  always #5 clk = ~clk;

  uart_tx_param #(.DATA_WIDTH(8), .PRESC_W(6)) dut (
    .CLK(clk), .RST(rst_n), .P_DATA(p_data), .DATA_VALID(data_valid),
    .DATA_READY(data_ready), .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2),
    .PRESCALE(prescale), .TX_OUT(tx_out), .Busy(busy)
  );

  uart_tx_param #(.DATA_WIDTH(7), .PRESC_W(6)) u7 (
    .CLK(clk), .RST(rst_n), .P_DATA(d7), .DATA_VALID(v7),
    .DATA_READY(r7), .PAR_EN(1'b1), .PAR_TYP(1'b0), .STOP2(1'b0),
    .PRESCALE(6'd1), .TX_OUT(tx7), .Busy(busy7)
  );

  typedef struct {
    logic [7:0]  data;
    logic        pe;
    logic        pt;
    logic        s2;
    logic [5:0]  pr;
    logic [15:0] bits;
    int          nbits;
    int          cyc;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Frame as a list of line bits, first bit in position 0.
  function automatic void model(input logic [7:0] d, input logic pe, input logic pt,
                                input logic s2, output logic [15:0] bits, output int n);
    int ones;
    ones = 0;
    n = 0;
    bits = '0;
    bits[n] = 1'b0; n++;
    for (int k = 0; k < 8; k++) begin
      bits[n] = 1'(((int'(d)) >> k) % 2);
      ones += ((int'(d)) >> k) % 2;
      n++;
    end
    if (pe) begin
      bits[n] = (pt == PAR_ODD) ? 1'((ones % 2) == 0) : 1'((ones % 2) == 1);
      n++;
    end
    bits[n] = 1'b1; n++;
    if (s2) begin
      bits[n] = 1'b1; n++;
    end
  endfunction

  // Expand a bit list into one line value per clock.
  function automatic logic [127:0] expand(input logic [15:0] bits, input int n, input int p);
    logic [127:0] s;
    int idx;
    int pp;
    s = '0;
    idx = 0;
    pp = (p < 1) ? 1 : p;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < pp; j++) begin
        s[idx] = bits[i];
        idx++;
      end
    return s;
  endfunction

  task automatic run_frame(input string name, input logic [7:0] d, input logic pe, input logic pt,
                           input logic s2, input logic [5:0] pr, input logic [15:0] bits,
                           input int nbits, input int cyc);
    int bc, guard, total;
    total = nbits * ((pr == 6'd0) ? 1 : int'(pr));
    @(negedge clk);
    p_data = d; par_en = pe; par_typ = pt; stop2 = s2; prescale = pr; data_valid = 1'b1;
    guard = 0;
    while (!data_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check({name, "_ready"}, 128'(data_ready), 128'(1));
    if (!data_ready) begin
      data_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    data_valid = 1'b0;
    p_data = ~d; par_en = ~pe; par_typ = ~pt; stop2 = ~s2; prescale = 6'($urandom);
    check({name, "_lat"}, 128'({tx_out, busy}), 128'(2'b10));
    cap = '0;
    bc = 0;
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      cap[c] = tx_out;
      bc += int'(busy);
    end
    check({name, "_frame"}, cap, expand(bits, nbits, int'(pr)));
    check({name, "_busy"}, 128'(bc), 128'(cyc));
    @(negedge clk);
    check({name, "_idle"}, 128'({tx_out, busy}), 128'(2'b10));
  endtask

  // Second word presented while busy: hold build chains with no gap,
  // plain build waits for IDLE and leaves one idle-high cycle.
  task automatic back_to_back();
    logic [15:0] b1, b2;
    logic [127:0] exp_s;
    int n1, n2, gap, total, idx, guard;
    model(8'h2E, 1'b1, 1'b0, 1'b0, b1, n1);
    model(8'hA5, 1'b1, 1'b0, 1'b0, b2, n2);
    gap = HOLD ? 0 : 1;
    exp_s = '0;
    idx = 0;
    for (int i = 0; i < n1; i++) begin exp_s[idx] = b1[i]; idx++; end
    for (int i = 0; i < gap; i++) begin exp_s[idx] = 1'b1; idx++; end
    for (int i = 0; i < n2; i++) begin exp_s[idx] = b2[i]; idx++; end
    total = idx;
    @(negedge clk);
    p_data = 8'h2E; par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b0; prescale = 6'd1; data_valid = 1'b1;
    guard = 0;
    while (!data_ready && guard < 300) begin @(negedge clk); guard++; end
    check("b2b_first_ready", 128'(data_ready), 128'(1));
    @(posedge clk);
    @(negedge clk);
    data_valid = 1'b0;
    cap = '0;
    fork
      begin
        for (int c = 0; c < total; c++) begin
          @(negedge clk);
          cap[c] = tx_out;
        end
      end
      begin
        int g;
        @(negedge clk);
        @(negedge clk);
        check("b2b_ready_busy", 128'({busy, data_ready}), 128'({1'b1, HOLD}));
        p_data = 8'hA5; par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b0; prescale = 6'd1;
        data_valid = 1'b1;
        g = 0;
        while (!data_ready && g < 100) begin @(negedge clk); g++; end
        if (data_ready) begin
          @(posedge clk);
          @(negedge clk);
        end
        data_valid = 1'b0;
        p_data = 8'h00;
      end
    join
    check("b2b_stream", cap, exp_s);
    @(negedge clk);
    check("b2b_idle", 128'({tx_out, busy, data_ready}), 128'(3'b101));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] mb;
    int mn, guard, bc;
    logic [7:0] rd;
    logic rpe, rpt, rs2;
    logic [5:0] rpr;

    tbl[0] = '{8'h2E, 1'b1, 1'b0, 1'b0, 6'd1, 16'h045C, 11, 11};
    tbl[1] = '{8'h2E, 1'b1, 1'b1, 1'b0, 6'd1, 16'h065C, 11, 11};
    tbl[2] = '{8'hAE, 1'b1, 1'b0, 1'b0, 6'd1, 16'h075C, 11, 11};
    tbl[3] = '{8'hAE, 1'b1, 1'b1, 1'b0, 6'd1, 16'h055C, 11, 11};
    tbl[4] = '{8'hAE, 1'b0, 1'b0, 1'b0, 6'd1, 16'h035C, 10, 10};
    tbl[5] = '{8'h55, 1'b0, 1'b0, 1'b1, 6'd4, 16'h06AA, 11, 44};
    tbl[6] = '{8'h2E, 1'b1, 1'b0, 1'b0, 6'd0, 16'h045C, 11, 11};

    rst_n = 1'b0;
    p_data = '0; data_valid = 1'b0; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0; prescale = 6'd1;
    d7 = '0; v7 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", 128'({tx_out, busy, data_ready}), 128'(3'b101));
    check("reset_state7", 128'({tx7, busy7, r7}), 128'(3'b101));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++)
      run_frame($sformatf("tbl%0d", i), tbl[i].data, tbl[i].pe, tbl[i].pt, tbl[i].s2,
                tbl[i].pr, tbl[i].bits, tbl[i].nbits, tbl[i].cyc);

    for (int i = 0; i < 25; i++) begin
      rd  = 8'($urandom);
      rpe = 1'($urandom);
      rpt = 1'($urandom);
      rs2 = 1'($urandom);
      rpr = 6'($urandom_range(0, 5));
      model(rd, rpe, rpt, rs2, mb, mn);
      run_frame($sformatf("rnd%0d", i), rd, rpe, rpt, rs2, rpr, mb, mn,
                mn * ((rpr == 6'd0) ? 1 : int'(rpr)));
    end

    back_to_back();

    // 7-bit instance: 0x41 with even parity.
    @(negedge clk);
    d7 = 7'h41; v7 = 1'b1;
    guard = 0;
    while (!r7 && guard < 300) begin @(negedge clk); guard++; end
    check("w7_ready", 128'(r7), 128'(1));
    @(posedge clk);
    @(negedge clk);
    v7 = 1'b0; d7 = 7'h3E;
    cap = '0;
    bc = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      cap[c] = tx7;
      bc += int'(busy7);
    end
    check("w7_frame", cap, expand(16'h0282, 10, 1));
    check("w7_busy", 128'(bc), 128'(10));

    // Reset during data bit 3 of 0x55 at prescale 4 (line low there).
    @(negedge clk);
    p_data = 8'h55; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0; prescale = 6'd4; data_valid = 1'b1;
    guard = 0;
    while (!data_ready && guard < 300) begin @(negedge clk); guard++; end
    @(posedge clk);
    @(negedge clk);
    data_valid = 1'b0;
    for (int c = 0; c < 18; c++) @(negedge clk);
    check("rst_pre", 128'({tx_out, busy}), 128'(2'b01));
    rst_n = 1'b0;
    #1;
    check("rst_async", 128'({tx_out, busy, data_ready}), 128'(3'b101));
    @(negedge clk);
    rst_n = 1'b1;
    run_frame("post_rst", 8'hAE, 1'b1, 1'b1, 1'b0, 6'd1, 16'h055C, 11, 11);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter: serialises a DATA_WIDTH-bit word LSB-first into a start, data, optional parity, and 1 or 2 stop-bit frame on a single line. Each bit lasts PRESCALE cycles of the system clock. Each frame's configuration is latched when the word is accepted, and an optional holding register allows gap-free back-to-back frames. It sits between the register-file/FIFO side of the system and the serial TX pin, replacing the fixed 8-bit, one-bit-per-clock transmitter.

## Interface
- DATA_WIDTH, 8, data bits per frame (5..9)
- PRESC_W, 6, width of PRESCALE input
- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  asynchronous, active-low reset
- P_DATA  in  DATA_WIDTH  word to send
- DATA_VALID  in  1  P_DATA valid
- DATA_READY  out  1  block can accept a word this cycle
- PAR_EN  in  1  1 = parity bit inserted
- PAR_TYP  in  1  0 = even, 1 = odd
- STOP2  in  1  1 = two stop bits
- PRESCALE  in  PRESC_W  clocks per bit; 0 is treated as 1
- TX_OUT  out  1  serial line, idle high
- Busy  out  1  frame in progress

## Operation
- Handshake: a word is accepted on a rising edge where DATA_VALID=1 and DATA_READY=1.
  - P_DATA, PAR_EN, PAR_TYP, STOP2 and PRESCALE are latched together at acceptance.
  - Input changes after acceptance do not affect the frame in progress.
- DATA_VALID while DATA_READY=0 is ignored. The source holds the word until it is accepted.
- FSM states and transitions:
  - IDLE → START on accept (or on a full holding register).
  - START → DATA.
  - DATA → PARITY if PAR_EN, else → STOP.
  - PARITY → STOP.
  - STOP → STOP2 state if STOP2, else → IDLE / START.
  - STOP2 state → IDLE / START.
- Line values per state:
  - TX_OUT = 1 in IDLE and in both stop states; 0 in START.
  - In DATA, TX_OUT is data bit k for k = 0..DATA_WIDTH-1, LSB first.
  - Parity bit = ^data for even, ~^data for odd.
- Bit timer: down-counter reloaded with max(PRESCALE,1)-1 at each bit start. A bit ends when the counter reaches 0. The bit index counter is only advanced in DATA.
- Busy = 1 in every state except IDLE.
- Reset values: TX_OUT=1, Busy=0, DATA_READY=1, FSM=IDLE, counters 0, holding register empty.
- Reset asserted mid-frame aborts the frame: TX_OUT returns to 1 asynchronously and nothing is resumed.

## Timing
- TX_OUT and Busy are registered.
- The start bit appears from the first rising edge after the accepting edge, so latency from acceptance to the start-bit edge is 1 cycle.
- Frame length in bit periods: 1 + DATA_WIDTH + PAR_EN + 1 + STOP2. Each bit period is max(PRESCALE,1) cycles.
- With PRESCALE=1, DATA_WIDTH=8, PAR_EN=1, STOP2=0, the frame is exactly 11 consecutive cycles, one bit per cycle.
- Without holding register:
  - DATA_READY = (FSM==IDLE).
  - Consecutive frames are separated by at least 1 idle-high cycle.

## Configuration
- Macro UART_TX_HOLD_EN selects a one-word holding register (data plus latched configuration).
- With UART_TX_HOLD_EN:
  - DATA_READY = holding register empty, so a word can be accepted while Busy=1.
  - At the last cycle of the final stop bit, if the holding register is full, the FSM goes directly to START. The next start bit follows the last stop bit with 0 idle cycles and Busy stays 1.
  - The holding register empties on that transition, and DATA_READY rises the same edge.
  - Accepting from IDLE with an empty holding register behaves identically to the non-macro case.
- Without UART_TX_HOLD_EN: no holding register; DATA_READY = (FSM==IDLE).

## Structure
- Package uart_pkg holds:
  - the FSM state enum typedef (IDLE, START, DATA, PARITY, STOP, STOP2);
  - parity type constants PAR_EVEN=0 and PAR_ODD=1;
  - default DATA_WIDTH and PRESC_W constants.
- Sub-module uart_tx_bit_timer: prescale down-counter with load and bit_done outputs, shared with the future receiver.

## Test plan
- Reset, then P_DATA=0x2E, PAR_EN=1, PAR_TYP=0, PRESCALE=1 → TX_OUT over 11 cycles = 0,0,1,1,1,0,1,0,0,0,1; Busy high for exactly 11 cycles.
- Same with PAR_TYP=1, then 0xAE even (parity=1), 0xAE odd (parity=0), and 0xAE no parity → correct parity bit in each case; the no-parity frame is 10 bits.
- PRESCALE=4, STOP2=1, 0x55 no parity → each bit is held exactly 4 cycles; frame is 44 cycles; the two stop bits give 8 high cycles.
- DATA_WIDTH=7 instance, P_DATA=0x41, even parity → 10-bit frame, parity bit 0; the input bit above bit 6 is ignored.
- UART_TX_HOLD_EN, second word 0xA5 presented while Busy → accepted mid-frame; start bit follows the prior stop bit with 0 idle cycles.
- Without the macro, the same second word is held off with DATA_READY=0 until IDLE.
- RST pulsed low during data bit 3 → TX_OUT=1 and Busy=0 immediately; the next accepted frame is correct from its start bit.
